// File: rtl/inv_round_tail.sv
// AES decryption round tail: AddRoundKey followed by column-serial InvMixColumns
// (skipped on the final round), with a start/busy/done handshake.
module inv_round_tail #(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [0:127] state_in,
   input  logic [0:127] round_key,
   input  logic         last_round,
   output logic         busy,
   output logic         done,
   output logic [0:127] state_out
);

   localparam int unsigned NCOLS    = 4;
   localparam int unsigned COL_W    = 32;
   localparam logic [1:0]  COL_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0]  LAST_COL = 2'(NCOLS - COLS_PER_CYCLE);

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
         $error("inv_round_tail: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, MIX, OUT} fsm_t;

   fsm_t         fsm;
   logic [0:127] work;
   logic [0:127] mixed;
   logic [1:0]   col;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One InvMixColumns column; byte 4c (row 0) sits at the MSB end of the word.
   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] s  [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int r = 0; r < 4; r++) begin
         s[r]  = c[31 - 8*r -: 8];
         x2[r] = xtime(s[r]);
         x4[r] = xtime(x2[r]);
         x8[r] = xtime(x4[r]);
         m9[r] = x8[r] ^ s[r];
         mb[r] = x8[r] ^ x2[r] ^ s[r];
         md[r] = x8[r] ^ x4[r] ^ s[r];
         me[r] = x8[r] ^ x4[r] ^ x2[r];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   // Columns col .. col+COLS_PER_CYCLE-1 transformed, the rest passed through.
   always_comb begin
      mixed = work;
      for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
         mixed[COL_W*(int'(col) + k) +: COL_W] = inv_mix_col(work[COL_W*(int'(col) + k) +: COL_W]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm       <= IDLE;
         work      <= '0;
         col       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         state_out <= '0;
      end else begin
         done <= 1'b0;
         case (fsm)
            IDLE: begin
               if (start) begin
                  work <= state_in ^ round_key;
                  col  <= '0;
                  busy <= 1'b1;
                  fsm  <= last_round ? OUT : MIX;
               end
            end
            MIX: begin
               work <= mixed;
               col  <= col + COL_STEP;
               if (col == LAST_COL) fsm <= OUT;
            end
            OUT: begin
               state_out <= work;
               done      <= 1'b1;
               busy      <= 1'b0;
               fsm       <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_round_tail.sv
// Checks inv_round_tail for COLS_PER_CYCLE = 1, 2, 4 side by side against
// directed vectors, handshake corner cases and a GF(2^8) reference model.
module tb_inv_round_tail;

   localparam int NDUT = 3;
   localparam int CPC [NDUT] = '{1, 2, 4};

   logic         clk = 1'b0;
   logic         rst;
   logic         start_v [NDUT];
   logic [0:127] state_in;
   logic [0:127] round_key;
   logic         last_round;
   logic         busy_o  [NDUT];
   logic         done_o  [NDUT];
   logic [0:127] so      [NDUT];

   int n_cmp = 0;
   int n_bad = 0;

   int           got_lat  [NDUT];
   int           done_cnt [NDUT];
   int           busy_cnt [NDUT];
   logic [0:127] got_out  [NDUT];

   always #5 clk = ~clk;

   inv_round_tail #(.COLS_PER_CYCLE(1)) u_c1 (
      .clk(clk), .rst(rst), .start(start_v[0]), .state_in(state_in), .round_key(round_key),
      .last_round(last_round), .busy(busy_o[0]), .done(done_o[0]), .state_out(so[0]));
   inv_round_tail #(.COLS_PER_CYCLE(2)) u_c2 (
      .clk(clk), .rst(rst), .start(start_v[1]), .state_in(state_in), .round_key(round_key),
      .last_round(last_round), .busy(busy_o[1]), .done(done_o[1]), .state_out(so[1]));
   inv_round_tail #(.COLS_PER_CYCLE(4)) u_c4 (
      .clk(clk), .rst(rst), .start(start_v[2]), .state_in(state_in), .round_key(round_key),
      .last_round(last_round), .busy(busy_o[2]), .done(done_o[2]), .state_out(so[2]));

   // Reference model: plain shift-and-add GF(2^8) multiply, matrix form.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? (8'(aa << 1) ^ 8'h1b) : 8'(aa << 1);
      end
      return p;
   endfunction

   function automatic logic [0:127] ref_model(input logic [0:127] si, input logic [0:127] rk,
                                              input logic lr);
      logic [7:0]   m [4][4];
      logic [0:127] w = si ^ rk;
      logic [0:127] r = w;
      logic [7:0]   acc;
      m[0] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      m[1] = '{8'h09, 8'h0e, 8'h0b, 8'h0d};
      m[2] = '{8'h0d, 8'h09, 8'h0e, 8'h0b};
      m[3] = '{8'h0b, 8'h0d, 8'h09, 8'h0e};
      if (lr) return w;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[row][j], w[8*(4*c + j) +: 8]);
            r[8*(4*c + row) +: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic int exp_lat(input int d, input logic lr);
      return lr ? 1 : 1 + 4 / CPC[d];
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic set_start(input logic v);
      for (int d = 0; d < NDUT; d++) start_v[d] = v;
   endtask

   // One operation on all DUTs; poke holds start one extra edge with altered inputs.
   task automatic run_op(input logic [0:127] si, input logic [0:127] rk, input logic lr,
                         input bit poke);
      @(negedge clk);
      state_in = si; round_key = rk; last_round = lr;
      set_start(1'b1);
      @(posedge clk); #1;
      for (int d = 0; d < NDUT; d++) begin
         got_lat[d] = 0; done_cnt[d] = 0; got_out[d] = '0;
         busy_cnt[d] = busy_o[d] ? 1 : 0;
      end
      if (poke) begin
         state_in = ~si; round_key = si; last_round = ~lr;
      end else begin
         set_start(1'b0);
      end
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         if (poke && n == 1) set_start(1'b0);
         for (int d = 0; d < NDUT; d++) begin
            if (busy_o[d]) busy_cnt[d]++;
            if (done_o[d]) begin
               done_cnt[d]++;
               if (got_lat[d] == 0) begin
                  got_lat[d] = n;
                  got_out[d] = so[d];
               end
            end
         end
      end
   endtask

   task automatic check_op(input string name, input logic [0:127] exp, input logic lr);
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("%s_c%0d_latency", name, CPC[d]), 128'(got_lat[d]), 128'(exp_lat(d, lr)));
         chk($sformatf("%s_c%0d_state_out", name, CPC[d]), got_out[d], exp);
         chk($sformatf("%s_c%0d_done_width", name, CPC[d]), 128'(done_cnt[d]), 128'(1));
         chk($sformatf("%s_c%0d_busy_span", name, CPC[d]), 128'(busy_cnt[d]), 128'(exp_lat(d, lr)));
      end
   endtask

   typedef struct {
      string        name;
      logic [0:127] si;
      logic [0:127] rk;
      logic         lr;
      logic [0:127] exp;
   } vec_t;

   initial begin
      vec_t         vecs [4];
      logic [0:127] si, rk, expv;
      logic         lr;
      int           n;

      vecs[0] = '{"mix_vector", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0, 1'b0,
                  128'hdb135345_f20a225c_01010101_c6c6c6c6};
      vecs[1] = '{"last_round", 128'h00112233445566778899aabbccddeeff,
                  128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                  128'h00102030405060708090a0b0c0d0e0f0};
      vecs[2] = '{"key_cancel", {16{8'ha5}}, {16{8'ha5}}, 1'b0, 128'h0};
      vecs[3] = '{"key_only", 128'h0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0,
                  128'hdb135345_f20a225c_01010101_c6c6c6c6};

      rst = 1'b1;
      set_start(1'b0);
      state_in = '0; round_key = '0; last_round = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("reset_c%0d_state_out", CPC[d]), so[d], 128'h0);
         chk($sformatf("reset_c%0d_busy_done", CPC[d]), {busy_o[d], done_o[d]}, 2'b00);
      end
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         run_op(vecs[i].si, vecs[i].rk, vecs[i].lr, 1'b0);
         check_op(vecs[i].name, vecs[i].exp, vecs[i].lr);
      end

      // Extra start mid-operation with different data must be ignored.
      run_op(vecs[0].si, vecs[0].rk, vecs[0].lr, 1'b1);
      check_op("start_while_busy", vecs[0].exp, vecs[0].lr);

      // Reset in the middle of an operation aborts it.
      @(negedge clk);
      state_in = vecs[2].si ^ 128'h1; round_key = '0; last_round = 1'b0;
      set_start(1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("abort_c%0d_state_out", CPC[d]), so[d], 128'h0);
         chk($sformatf("abort_c%0d_busy_done", CPC[d]), {busy_o[d], done_o[d]}, 2'b00);
      end
      @(negedge clk); rst = 1'b0;
      for (int d = 0; d < NDUT; d++) done_cnt[d] = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         for (int d = 0; d < NDUT; d++) if (done_o[d] || busy_o[d]) done_cnt[d]++;
      end
      for (int d = 0; d < NDUT; d++)
         chk($sformatf("abort_c%0d_no_done", CPC[d]), 128'(done_cnt[d]), 128'(0));

      // Back-to-back: start raised in the done cycle is accepted.
      for (int d = 0; d < NDUT; d++) begin
         @(negedge clk);
         state_in = vecs[1].si; round_key = vecs[1].rk; last_round = vecs[1].lr;
         start_v[d] = 1'b1;
         @(posedge clk); #1;
         start_v[d] = 1'b0;
         n = 0;
         while (!done_o[d] && n < 12) begin
            @(posedge clk); #1;
            n++;
         end
         chk($sformatf("b2b_c%0d_first_latency", CPC[d]), 128'(n), 128'(exp_lat(d, 1'b1)));
         chk($sformatf("b2b_c%0d_first_out", CPC[d]), so[d], vecs[1].exp);
         state_in = vecs[0].si; round_key = vecs[0].rk; last_round = vecs[0].lr;
         start_v[d] = 1'b1;
         @(posedge clk); #1;
         start_v[d] = 1'b0;
         chk($sformatf("b2b_c%0d_done_cleared", CPC[d]), 128'(done_o[d]), 128'(0));
         chk($sformatf("b2b_c%0d_out_stable", CPC[d]), so[d], vecs[1].exp);
         n = 0;
         while (!done_o[d] && n < 12) begin
            @(posedge clk); #1;
            n++;
         end
         chk($sformatf("b2b_c%0d_second_latency", CPC[d]), 128'(n), 128'(exp_lat(d, 1'b0)));
         chk($sformatf("b2b_c%0d_second_out", CPC[d]), so[d], vecs[0].exp);
      end

      // Random regression against the reference model.
      for (int i = 0; i < 1000; i++) begin
         si = {$urandom, $urandom, $urandom, $urandom};
         rk = {$urandom, $urandom, $urandom, $urandom};
         lr = 1'($urandom_range(0, 3) == 0);
         expv = ref_model(si, rk, lr);
         run_op(si, rk, lr, 1'b0);
         check_op($sformatf("rand%0d", i), expv, lr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
